// File: rtl/mod_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mod_seq_ctrl
//  Purpose  : Step sequencer for the oscillator modulation-mode select. Walks
//             a programmable table of (mode, dwell) entries while run is high.
//             Entering multiply mode (3'b011) masks mod_valid for MULT_LAT
//             clocks so the clocked multiplier can produce fresh output.
//  Options  : MODSEQ_PINGPONG_EN - walk the table 0..len..0 (ping-pong)
//             instead of 0..len then back to 0.
//  Revision : 1.0  initial release
// ============================================================================
module mod_seq_ctrl #(
    parameter int  STEPS    = 8,
    parameter int  DW       = 8,
    parameter int  MULT_LAT = 2,
    localparam int AW       = $clog2(STEPS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    input  logic          sample_tick,
    input  logic [AW-1:0] len,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [2:0]    wr_sel,
    input  logic [DW-1:0] wr_dwell,
    output logic [2:0]    modSel,
    output logic [AW-1:0] step,
    output logic          mod_valid,
    output logic          wrap,
    output logic          busy
);

    localparam logic [2:0] SEL_RST  = 3'b100;
    localparam logic [2:0] SEL_MULT = 3'b011;
    // Settle counter only needs to hold MULT_LAT-1
    localparam int         SW       = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SETTLE = 2'd2,
        DWELL  = 2'd3
    } state_t;

    state_t        state_q;
    logic [2:0]    modsel_q;
    logic [AW-1:0] step_q;
    logic          mod_valid_q;
    logic          wrap_q;
    logic          busy_q;
    logic [DW-1:0] dcnt_q;
    logic [SW-1:0] scnt_q;

    logic [2:0]    tbl_sel_q   [STEPS];
    logic [DW-1:0] tbl_dwell_q [STEPS];

    // Next step index / wrap flag used when a dwell expires
    logic [AW-1:0] step_d;
    logic          wrap_d;

`ifdef MODSEQ_PINGPONG_EN
    logic          dir_q;   // 0 = counting up, 1 = counting down
    logic          dir_d;
`endif

    // Compute the step that follows the current one when the dwell expires
    always_comb begin
        step_d = step_q + 1'b1;
        wrap_d = 1'b0;
`ifdef MODSEQ_PINGPONG_EN
        dir_d  = dir_q;
        if (len == '0) begin
            step_d = '0;
            wrap_d = 1'b1;
            dir_d  = 1'b0;
        end else if (!dir_q) begin
            // Top reached (or len shrank below us): turn around
            if (step_q >= len) begin
                step_d = step_q - 1'b1;
                wrap_d = 1'b1;
                dir_d  = 1'b1;
            end
        end else begin
            if (step_q == '0) begin
                step_d = AW'(1);
                wrap_d = 1'b1;
                dir_d  = 1'b0;
            end else begin
                step_d = step_q - 1'b1;
            end
        end
`else
        // >= so that a len lowered below the current step still wraps
        if (step_q >= len) begin
            step_d = '0;
            wrap_d = 1'b1;
        end
`endif
    end

    // Table storage; writes accepted in any state, reads in LOAD see old data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STEPS; i++) begin
                tbl_sel_q[i]   <= SEL_RST;
                tbl_dwell_q[i] <= '0;
            end
        end else if (wr_en) begin
            tbl_sel_q[wr_addr]   <= wr_sel;
            tbl_dwell_q[wr_addr] <= wr_dwell;
        end
    end

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            modsel_q    <= SEL_RST;
            step_q      <= '0;
            mod_valid_q <= 1'b0;
            wrap_q      <= 1'b0;
            busy_q      <= 1'b0;
            dcnt_q      <= '0;
            scnt_q      <= '0;
`ifdef MODSEQ_PINGPONG_EN
            dir_q       <= 1'b0;
`endif
        end else begin
            wrap_q <= 1'b0;
            if (!run) begin
                // Stop from any state; modSel intentionally keeps its value
                state_q     <= IDLE;
                step_q      <= '0;
                mod_valid_q <= 1'b0;
                busy_q      <= 1'b0;
`ifdef MODSEQ_PINGPONG_EN
                dir_q       <= 1'b0;
`endif
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= LOAD;
                        busy_q  <= 1'b1;
                    end
                    LOAD: begin
                        modsel_q <= tbl_sel_q[step_q];
                        dcnt_q   <= tbl_dwell_q[step_q];
                        // Only a transition into multiply mode needs settling
                        if ((tbl_sel_q[step_q] == SEL_MULT) && (modsel_q != SEL_MULT)) begin
                            state_q     <= SETTLE;
                            scnt_q      <= SW'(MULT_LAT - 1);
                            mod_valid_q <= 1'b0;
                        end else begin
                            state_q     <= DWELL;
                            mod_valid_q <= 1'b1;
                        end
                    end
                    SETTLE: begin
                        if (scnt_q == '0) begin
                            state_q     <= DWELL;
                            mod_valid_q <= 1'b1;
                        end else begin
                            scnt_q <= scnt_q - 1'b1;
                        end
                    end
                    DWELL: begin
                        if (sample_tick) begin
                            if (dcnt_q != '0) begin
                                dcnt_q <= dcnt_q - 1'b1;
                            end else begin
                                step_q  <= step_d;
                                wrap_q  <= wrap_d;
                                state_q <= LOAD;
`ifdef MODSEQ_PINGPONG_EN
                                dir_q   <= dir_d;
`endif
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign modSel    = modsel_q;
    assign step      = step_q;
    assign mod_valid = mod_valid_q;
    assign wrap      = wrap_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mod_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mod_seq_ctrl
//  Purpose  : Scoreboard bench for mod_seq_ctrl. Each output-vector change is
//             matched in order against hand-computed expected events; a few
//             cycle-exact points are checked directly.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mod_seq_ctrl;

    localparam int STEPS    = 8;
    localparam int DW       = 8;
    localparam int MULT_LAT = 2;
    localparam int AW       = 3;

    logic          clk;
    logic          rst_n;
    logic          run;
    logic          sample_tick;
    logic [AW-1:0] len;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [2:0]    wr_sel;
    logic [DW-1:0] wr_dwell;
    logic [2:0]    modSel;
    logic [AW-1:0] step;
    logic          mod_valid;
    logic          wrap;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected event = {busy, mod_valid, wrap, modSel, step}
    logic [8:0] exp_q [$];

    mod_seq_ctrl #(
        .STEPS    (STEPS),
        .DW       (DW),
        .MULT_LAT (MULT_LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .sample_tick (sample_tick),
        .len         (len),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_sel      (wr_sel),
        .wr_dwell    (wr_dwell),
        .modSel      (modSel),
        .step        (step),
        .mod_valid   (mod_valid),
        .wrap        (wrap),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [8:0] ev(input logic b, input logic m, input logic w,
                                      input logic [2:0] s, input logic [2:0] st);
        return {b, m, w, s, st};
    endfunction

    task automatic push(input logic [8:0] e);
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_tests++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", name, got, req, $time);
        end
    endtask

    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    // One sample tick seen at the next edge, followed by 9 quiet clocks
    task automatic tick();
        sample_tick = 1'b1;
        clk_step();
        sample_tick = 1'b0;
        repeat (9) clk_step();
    endtask

    task automatic wr(input logic [2:0] a, input logic [2:0] s, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_sel = s; wr_dwell = d;
        clk_step();
        wr_en = 1'b0;
    endtask

    // Monitor: every change of the output vector must match the queue head
    initial begin : monitor
        logic [8:0] prev;
        logic [8:0] cur;
        logic [8:0] e;
        prev = ev(1'b0, 1'b0, 1'b0, 3'b100, 3'd0);
        forever begin
            @(negedge clk);
            cur = {busy, mod_valid, wrap, modSel, step};
            if (cur !== prev) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL event_unexpected: got %b required none at %0t", cur, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        n_fail++;
                        $display("FAIL event: got %b required %b at %0t", cur, e, $time);
                    end
                end
            end
            prev = cur;
        end
    end

    initial begin : stim
        rst_n = 1'b1; run = 1'b0; sample_tick = 1'b0; len = '0;
        wr_en = 1'b0; wr_addr = '0; wr_sel = '0; wr_dwell = '0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_modSel", 32'(modSel), 32'h4);
        check("rst_step", 32'(step), 32'h0);
        check("rst_valid", 32'(mod_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_wrap", 32'(wrap), 32'h0);
        repeat (2) clk_step();
        rst_n = 1'b1;
        clk_step();

`ifdef MODSEQ_PINGPONG_EN
        // T6: ping-pong order 0,1,2,1,0,1,2 with wraps at the turns
        wr(3'd0, 3'b000, 8'd0);
        wr(3'd1, 3'b001, 8'd0);
        wr(3'd2, 3'b010, 8'd0);
        len = 3'd2;
        push(ev(1,0,0,3'b100,3'd0)); push(ev(1,1,0,3'b000,3'd0));
        push(ev(1,1,0,3'b000,3'd1)); push(ev(1,1,0,3'b001,3'd1));
        push(ev(1,1,0,3'b001,3'd2)); push(ev(1,1,0,3'b010,3'd2));
        push(ev(1,1,1,3'b010,3'd1)); push(ev(1,1,0,3'b001,3'd1));
        push(ev(1,1,0,3'b001,3'd0)); push(ev(1,1,0,3'b000,3'd0));
        push(ev(1,1,1,3'b000,3'd1)); push(ev(1,1,0,3'b001,3'd1));
        push(ev(1,1,0,3'b001,3'd2)); push(ev(1,1,0,3'b010,3'd2));
        run = 1'b1;
        repeat (3) clk_step();
        repeat (6) tick();
        // Stop resets the direction: restart climbs from 0
        push(ev(0,0,0,3'b010,3'd0));
        push(ev(1,0,0,3'b010,3'd0)); push(ev(1,1,0,3'b000,3'd0));
        push(ev(1,1,0,3'b000,3'd1)); push(ev(1,1,0,3'b001,3'd1));
        run = 1'b0;
        clk_step();
        run = 1'b1;
        repeat (3) clk_step();
        tick();
`else
        // T2: basic two-step sequence, two passes
        wr(3'd0, 3'b000, 8'd1);
        wr(3'd1, 3'b110, 8'd0);
        len = 3'd1;
        push(ev(1,0,0,3'b100,3'd0)); push(ev(1,1,0,3'b000,3'd0));
        for (int p = 0; p < 2; p++) begin
            push(ev(1,1,0,3'b000,3'd1)); push(ev(1,1,0,3'b110,3'd1));
            push(ev(1,1,1,3'b110,3'd0)); push(ev(1,1,0,3'b000,3'd0));
        end
        run = 1'b1;
        repeat (3) clk_step();
        repeat (6) tick();

        // T4: write to index 1 during its LOAD clock uses old contents
        push(ev(1,1,0,3'b000,3'd1)); push(ev(1,1,0,3'b110,3'd1));
        push(ev(1,1,1,3'b110,3'd0)); push(ev(1,1,0,3'b000,3'd0));
        push(ev(1,1,0,3'b000,3'd1)); push(ev(1,1,0,3'b111,3'd1));
        push(ev(1,1,1,3'b111,3'd0)); push(ev(1,1,0,3'b000,3'd0));
        tick();
        sample_tick = 1'b1;
        clk_step();
        sample_tick = 1'b0;
        wr_en = 1'b1; wr_addr = 3'd1; wr_sel = 3'b111; wr_dwell = 8'd0;
        clk_step();
        wr_en = 1'b0;
        repeat (8) clk_step();
        repeat (4) tick();

        // T3: multiply-mode settle window, ticks ignored while settling
        wr(3'd1, 3'b011, 8'd1);
        push(ev(1,1,0,3'b000,3'd1)); push(ev(1,0,0,3'b011,3'd1));
        push(ev(1,1,0,3'b011,3'd1));
        push(ev(1,1,1,3'b011,3'd0)); push(ev(1,1,0,3'b000,3'd0));
        tick();
        sample_tick = 1'b1;
        clk_step();                 // advance edge
        clk_step();                 // LOAD edge
        check("settle_sel", 32'(modSel), 32'h3);
        check("settle_valid0", 32'(mod_valid), 32'h0);
        clk_step();
        check("settle_valid1", 32'(mod_valid), 32'h0);
        clk_step();
        check("settle_valid2", 32'(mod_valid), 32'h1);
        sample_tick = 1'b0;
        repeat (8) clk_step();
        tick();                     // dwell 1 -> 0, still on step 1
        check("settle_nodec_step", 32'(step), 32'h1);
        tick();

        // T5: stop at step 3, then restart at step 0
        wr(3'd2, 3'b001, 8'd0);
        wr(3'd3, 3'b010, 8'd0);
        len = 3'd3;
        push(ev(1,1,0,3'b000,3'd1)); push(ev(1,0,0,3'b011,3'd1));
        push(ev(1,1,0,3'b011,3'd1));
        push(ev(1,1,0,3'b011,3'd2)); push(ev(1,1,0,3'b001,3'd2));
        push(ev(1,1,0,3'b001,3'd3)); push(ev(1,1,0,3'b010,3'd3));
        push(ev(0,0,0,3'b010,3'd0));
        push(ev(1,0,0,3'b010,3'd0)); push(ev(1,1,0,3'b000,3'd0));
        repeat (5) tick();
        run = 1'b0;
        clk_step();
        check("stop_modSel", 32'(modSel), 32'h2);
        check("stop_step", 32'(step), 32'h0);
        check("stop_valid", 32'(mod_valid), 32'h0);
        check("stop_busy", 32'(busy), 32'h0);
        run = 1'b1;
        repeat (3) clk_step();

        // len=0 with a multiply entry: settles once, re-LOAD does not re-settle
        wr(3'd0, 3'b011, 8'd0);
        len = 3'd0;
        push(ev(1,1,1,3'b000,3'd0)); push(ev(1,0,0,3'b011,3'd0));
        push(ev(1,1,0,3'b011,3'd0));
        push(ev(1,1,1,3'b011,3'd0)); push(ev(1,1,0,3'b011,3'd0));
        push(ev(1,1,1,3'b011,3'd0)); push(ev(1,1,0,3'b011,3'd0));
        repeat (4) tick();
        check("len0_valid", 32'(mod_valid), 32'h1);

        // T1: asynchronous reset mid-DWELL, no clock edge needed
        push(ev(0,0,0,3'b100,3'd0));
        rst_n = 1'b0;
        #1;
        check("arst_modSel", 32'(modSel), 32'h4);
        check("arst_step", 32'(step), 32'h0);
        check("arst_valid", 32'(mod_valid), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        clk_step();
        rst_n = 1'b1;
        clk_step();
        // Table was reset as well: entry 0 now loads 3'b100
        push(ev(1,0,0,3'b100,3'd0)); push(ev(1,1,0,3'b100,3'd0));
        push(ev(0,0,0,3'b100,3'd0));
        repeat (4) clk_step();
        run = 1'b0;
        repeat (2) clk_step();
`endif

        repeat (5) clk_step();
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
